frame_buffer_writer: RTL and testbench
======================================

// Module: frame_buffer_writer
// PURPOSE
//  Sink end of the 160x120 pixel stream (x, y, colour, plot) produced by the draw_* blocks.
//  Writes accepted pixels into an internal 19200x9 frame-buffer RAM and exposes a registered
//  random-access read port for scan-out and region restore.
//  Provides a hardware full-screen clear and signals frame completion to the top-level FSM.
// PARAMETERS
//  SCR_W      160  screen width in pixels
//  SCR_H      120  screen height in pixels
//  COL_W      9    colour width (3 bits each of R, G, B)
//  DROP_W     8    width of the saturating drop counter
// PORTS
//  clk          in   1   system clock
//  resetn       in   1   synchronous, active-low reset
//  plot         in   1   pixel valid strobe
//  x            in   8   pixel column
//  y            in   7   pixel row
//  colour       in   9   pixel colour
//  clear_start  in   1   request full-screen fill
//  clear_colour in   9   fill colour; sampled with clear_start
//  rd_x         in   8   read column
//  rd_y         in   7   read row
//  rd_colour    out  9   registered read data
//  busy         out  1   high while state == CLEAR
//  frame_done   out  1   1-cycle pulse: pixel (159,119) accepted
//  clear_done   out  1   1-cycle pulse: last clear address issued
//  drop_count   out  8   saturating count of rejected plots
// BEHAVIOUR
//  Reset: state IDLE; pipeline valid 0; clear counter 0; rd_colour, busy, frame_done,
//    clear_done, drop_count all 0. RAM contents are not reset.
//  Address: addr = y*160 + x = (y<<7) + (y<<5) + x, 15 bits. Valid range 0..19199.
//  Write pipeline (shared by plot and clear): stage register {wr_valid, wr_addr, wr_data}.
//    Loaded at edge N; RAM written at edge N+1. One write per cycle; no stalls.
//  FSM states:
//    IDLE  -> CLEAR on clear_start
//    CLEAR -> IDLE after 19200 cycles
//  IDLE:
//    plot with x<160 && y<120 is accepted into the stage.
//    plot out of range is dropped; drop_count += 1, saturating at 255.
//    Accepted (159,119) -> frame_done high on the next cycle, for exactly 1 cycle.
//    clear_start: latch clear_colour; go to CLEAR at the same edge.
//      A plot in that same cycle is still accepted; the clear later overwrites it.
//  CLEAR:
//    Stage is loaded from the clear counter (0..19199), one address per cycle.
//    After address 19199 is loaded: -> IDLE, clear_done pulses 1 cycle, busy falls.
//      The final RAM write commits one edge later.
//    All plots are dropped and counted, including in-range ones. clear_start is ignored.
//  Read port:
//    rd_x/rd_y are sampled at edge M; rd_colour is valid after M.
//    Read-first on a same-edge collision (returns old data). No bypass.
//    A write staged at edge N is visible to a read sampled at edge N+2 or later.
//    rd_x >= 160 or rd_y >= 120 returns 0.
//  Reset mid-CLEAR: returns to IDLE at once; the pending stage write is discarded;
//    RAM is left partially cleared.
// STRUCTURE
//  Shared package: SCR_W, SCR_H, FB_DEPTH=19200, FB_AW=15, COL_W, state encodings.
//  Sub-module: pixel_addr_160x120, combinational (x, y) -> addr, instantiated twice
//    (write side and read side).
//  RAM inferred inline as a simple dual-port block (port A write, port B read).
// TESTING
//  1. plot (5,7)=0x1AB; read (5,7) two cycles later
//     -> rd_colour=0x1AB; internal addr 1125; drop_count=0.
//  2. plot (160,0), then (0,120)
//     -> no RAM change at addr 0; drop_count=2. Then 300 bad plots -> drop_count=255.
//  3. clear_start, clear_colour=0x000, after filling with 0x1FF
//     -> busy for 19200 cycles; clear_done pulses once;
//        reads (0,0) and (159,119) both return 0x000.
//  4. plot (10,10)=0x0F0 during CLEAR -> dropped, drop_count+1;
//     after clear, read (10,10) returns clear_colour.
//  5. plot (159,119)=0x007 -> frame_done high exactly 1 cycle, on the cycle after acceptance;
//     plot (158,119) -> no pulse.
//  6. resetn low at clear cycle 100 -> busy=0 next cycle;
//     a new plot (3,3)=0x055 is written normally; no clear_done pulse.

Source files
------------

// File: rtl/frame_buffer_writer_pkg.sv
// frame_buffer_writer_pkg: shared geometry, widths and state encoding for the frame-buffer writer
package frame_buffer_writer_pkg;
   localparam int SCR_W    = 160;
   localparam int SCR_H    = 120;
   localparam int FB_DEPTH = SCR_W * SCR_H;
   localparam int FB_AW    = 15;
   localparam int COL_W    = 9;
   localparam int DROP_W   = 8;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam logic [FB_AW-1:0] LAST_ADDR = FB_AW'(FB_DEPTH - 1);
   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
endpackage

// File: rtl/frame_buffer_writer_if.sv
// frame_buffer_writer_if: pixel stream (plot strobe, x, y, colour) from the draw blocks
//   master: drives plot/x/y/colour; slave: receives them
interface frame_buffer_writer_if;
   import frame_buffer_writer_pkg::*;
   logic             plot;
   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [COL_W-1:0] colour;
   modport master (output plot, x, y, colour);
   modport slave  (input  plot, x, y, colour);
endinterface

// File: rtl/frame_buffer_writer_pixel_addr_160x120.sv
// pixel_addr_160x120: combinational (x, y) -> linear frame-buffer address with range flag
//   x, y : pixel coordinates
//   addr : y*160 + x
//   ok   : coordinates lie inside the screen
module pixel_addr_160x120
   import frame_buffer_writer_pkg::*;
(
   input  logic [X_W-1:0]   x,
   input  logic [Y_W-1:0]   y,
   output logic [FB_AW-1:0] addr,
   output logic             ok
);
   assign addr = FB_AW'({y, 7'b0}) + FB_AW'({y, 5'b0}) + FB_AW'(x);
   assign ok   = x < X_W'(SCR_W) && y < Y_W'(SCR_H);
endmodule

// File: rtl/frame_buffer_writer.sv
// frame_buffer_writer: 160x120 pixel sink with frame-buffer RAM, hardware clear and read port
//   clk, resetn              : clock, synchronous active-low reset
//   pix                      : incoming pixel stream (slave side)
//   clear_start/clear_colour : full-screen fill request and its colour
//   rd_x, rd_y / rd_colour   : read address in, registered read data out
//   busy                     : clear in progress
//   frame_done, clear_done   : one-cycle completion pulses
//   drop_count               : saturating count of rejected plots
module frame_buffer_writer
   import frame_buffer_writer_pkg::*;
(
   input  logic                clk,
   input  logic                resetn,
   frame_buffer_writer_if.slave pix,
   input  logic                clear_start,
   input  logic [COL_W-1:0]    clear_colour,
   input  logic [X_W-1:0]      rd_x,
   input  logic [Y_W-1:0]      rd_y,
   output logic [COL_W-1:0]    rd_colour,
   output logic                busy,
   output logic                frame_done,
   output logic                clear_done,
   output logic [DROP_W-1:0]   drop_count
);
   state_t           state;
   logic [FB_AW-1:0] w_addr, r_addr, wr_addr, clr_cnt;
   logic             w_ok, r_ok, wr_valid, drop;
   logic [COL_W-1:0] wr_data, clr_col;
   logic [COL_W-1:0] mem [FB_DEPTH];
   pixel_addr_160x120 u_wr_addr (.x(pix.x), .y(pix.y), .addr(w_addr), .ok(w_ok));
   pixel_addr_160x120 u_rd_addr (.x(rd_x),  .y(rd_y),  .addr(r_addr), .ok(r_ok));
   // every plot during a clear is rejected, in range or not
   assign drop = pix.plot && (state == CLEAR || !w_ok);
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         wr_valid   <= 1'b0;
         clr_cnt    <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         clear_done <= 1'b0;
         drop_count <= '0;
      end else begin
         frame_done <= 1'b0;
         clear_done <= 1'b0;
         wr_valid   <= 1'b0;
         if (drop && drop_count != '1) drop_count <= drop_count + DROP_W'(1);
         if (state == IDLE) begin
            if (pix.plot && w_ok) begin
               wr_valid   <= 1'b1;
               wr_addr    <= w_addr;
               wr_data    <= pix.colour;
               frame_done <= w_addr == LAST_ADDR;
            end
            if (clear_start) begin
               state   <= CLEAR;
               busy    <= 1'b1;
               clr_cnt <= '0;
               clr_col <= clear_colour;
            end
         end else begin
            wr_valid <= 1'b1;
            wr_addr  <= clr_cnt;
            wr_data  <= clr_col;
            clr_cnt  <= clr_cnt == LAST_ADDR ? '0 : clr_cnt + FB_AW'(1);
            if (clr_cnt == LAST_ADDR) begin
               state      <= IDLE;
               busy       <= 1'b0;
               clear_done <= 1'b1;
            end
         end
      end
   end
   // a write still staged when reset arrives is dropped
   always_ff @(posedge clk) if (resetn && wr_valid) mem[wr_addr] <= wr_data;
   always_ff @(posedge clk) rd_colour <= !resetn ? '0 : r_ok ? mem[r_addr] : '0;
endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb_frame_buffer_writer: directed stimulus with an arithmetic reference model of the frame buffer
module tb_frame_buffer_writer;
   logic       clk = 1'b0;
   logic       resetn;
   logic       clear_start;
   logic [8:0] clear_colour;
   logic [7:0] rd_x;
   logic [6:0] rd_y;
   logic [8:0] rd_colour;
   logic       busy, frame_done, clear_done;
   logic [7:0] drop_count;
   int checks = 0;
   int errors = 0;
   frame_buffer_writer_if pif ();
   frame_buffer_writer dut (
      .clk(clk), .resetn(resetn), .pix(pif), .clear_start(clear_start), .clear_colour(clear_colour),
      .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour), .busy(busy), .frame_done(frame_done),
      .clear_done(clear_done), .drop_count(drop_count));
   always #5 clk = ~clk;
   function automatic void chk(string n, int act, int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", n, act, exp);
      end
   endfunction
   int  mem [19200];
   bit  m_live = 0;
   bit  m_busy, m_fd, m_cd, pv;
   int  m_drop, m_rd, clr_idx, clr_col, pa, pd;
   initial for (int i = 0; i < 19200; i++) mem[i] = -1;
   always @(posedge clk) begin
      int ra;
      if (!resetn) begin
         m_live = 1; m_busy = 0; m_fd = 0; m_cd = 0; m_drop = 0; m_rd = 0; pv = 0;
      end else begin
         ra = (rd_x < 160 && rd_y < 120) ? int'(rd_y) * 160 + int'(rd_x) : -1;
         m_rd = ra < 0 ? 0 : mem[ra];
         if (pv) mem[pa] = pd;
         pv = 0; m_fd = 0; m_cd = 0;
         if (m_busy) begin
            pv = 1; pa = clr_idx; pd = clr_col; clr_idx++;
            if (pif.plot) m_drop = m_drop < 255 ? m_drop + 1 : 255;
            if (clr_idx == 19200) begin m_busy = 0; m_cd = 1; end
         end else begin
            if (pif.plot && pif.x < 160 && pif.y < 120) begin
               pv = 1; pa = int'(pif.y) * 160 + int'(pif.x); pd = int'(pif.colour);
               m_fd = pif.x == 159 && pif.y == 119;
            end else if (pif.plot) m_drop = m_drop < 255 ? m_drop + 1 : 255;
            if (clear_start) begin m_busy = 1; clr_idx = 0; clr_col = int'(clear_colour); end
         end
      end
   end
   always @(negedge clk) if (m_live) begin
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, m_fd);
      chk("clear_done", clear_done, m_cd);
      chk("drop_count", drop_count, m_drop);
      if (m_rd >= 0) chk("rd_colour", rd_colour, m_rd);
   end
   task automatic plot_px(input int x, input int y, input int c);
      pif.plot = 1; pif.x = 8'(x); pif.y = 7'(y); pif.colour = 9'(c);
      @(negedge clk);
      pif.plot = 0;
   endtask
   task automatic rd_px(input int x, input int y, input int exp, input string n);
      rd_x = 8'(x); rd_y = 7'(y);
      @(negedge clk);
      chk(n, rd_colour, exp);
   endtask
   task automatic run_clear(input int col, output int bc, output int cd);
      clear_start = 1; clear_colour = 9'(col);
      pif.plot = 1; pif.x = 0; pif.y = 0; pif.colour = 9'h123;
      @(negedge clk);
      clear_start = 0; pif.plot = 0; bc = 0; cd = 0;
      for (int i = 0; i < 20000; i++) begin
         cd += int'(clear_done);
         if (!busy) break;
         bc++;
         pif.plot = i == 50; pif.x = 10; pif.y = 10; pif.colour = 9'h0F0;
         @(negedge clk);
      end
      pif.plot = 0;
      repeat (3) begin @(negedge clk); cd += int'(clear_done); end
   endtask
   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int bc, cd, fdc;
      pif.plot = 0; pif.x = 0; pif.y = 0; pif.colour = 0;
      clear_start = 0; clear_colour = 0; rd_x = 0; rd_y = 0; resetn = 0;
      repeat (2) @(negedge clk);
      chk("rst_rd", rd_colour, 0);
      chk("rst_busy", busy, 0);
      chk("rst_drop", drop_count, 0);
      chk("rst_fd", frame_done, 0);
      chk("rst_cd", clear_done, 0);
      resetn = 1;
      pif.plot = 1; pif.x = 5; pif.y = 7; pif.colour = 9'h1AB;
      @(negedge clk);
      pif.plot = 0;
      chk("stage_addr", int'(dut.wr_addr), 1125);
      chk("stage_valid", int'(dut.wr_valid), 1);
      @(negedge clk);
      rd_px(5, 7, 'h1AB, "t1_read");
      chk("t1_drop", drop_count, 0);
      plot_px(0, 0, 'h0AA);
      plot_px(160, 0, 'h155);
      plot_px(0, 120, 'h155);
      @(negedge clk);
      rd_px(0, 0, 'h0AA, "t2_addr0");
      chk("t2_drop2", drop_count, 2);
      for (int i = 0; i < 300; i++) plot_px(255, 127, 1);
      chk("t2_drop_sat", drop_count, 255);
      rd_px(200, 5, 0, "rd_oob_x");
      rd_px(5, 120, 0, "rd_oob_y");
      resetn = 0;
      @(negedge clk);
      resetn = 1;
      chk("t3_drop_rst", drop_count, 0);
      run_clear('h1FF, bc, cd);
      chk("t3_fill_busy", bc, 19200);
      chk("t3_fill_cd", cd, 1);
      chk("t4_drop1", drop_count, 1);
      rd_px(80, 60, 'h1FF, "t3_fill_read");
      run_clear('h000, bc, cd);
      chk("t3_busy_cycles", bc, 19200);
      chk("t3_cd_pulses", cd, 1);
      chk("t4_drop2", drop_count, 2);
      rd_px(0, 0, 0, "t3_read_0_0");
      rd_px(159, 119, 0, "t3_read_last");
      rd_px(10, 10, 0, "t4_read_10_10");
      pif.plot = 1; pif.x = 159; pif.y = 119; pif.colour = 9'h007;
      @(negedge clk);
      pif.plot = 0;
      chk("t5_fd_first", frame_done, 1);
      fdc = int'(frame_done);
      repeat (3) begin @(negedge clk); fdc += int'(frame_done); end
      chk("t5_fd_pulses", fdc, 1);
      plot_px(158, 119, 'h007);
      fdc = int'(frame_done);
      repeat (3) begin @(negedge clk); fdc += int'(frame_done); end
      chk("t5_no_fd", fdc, 0);
      rd_px(159, 119, 'h007, "t5_read");
      clear_start = 1; clear_colour = 9'h1C0;
      @(negedge clk);
      clear_start = 0; cd = 0;
      repeat (100) begin @(negedge clk); cd += int'(clear_done); end
      chk("t6_busy_mid", busy, 1);
      resetn = 0;
      @(negedge clk);
      chk("t6_busy_rst", busy, 0);
      resetn = 1;
      plot_px(3, 3, 'h055);
      cd += int'(clear_done);
      @(negedge clk);
      rd_px(3, 3, 'h055, "t6_plot_read");
      rd_px(0, 0, 'h1C0, "t6_partial_done");
      rd_px(0, 1, 0, "t6_partial_left");
      repeat (3) begin @(negedge clk); cd += int'(clear_done); end
      chk("t6_no_cd", cd, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
